// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: shifts a parallel word out MSB-first on 'a' after a valid/ready load,
// then drives GAP idle cycles. Define PARITY_EN to append an even parity bit after the LSB.
module serial_pattern_tx #(
  parameter int   WIDTH    = 8,
  parameter int   GAP      = 2,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             a,
  output logic             a_valid,
  output logic             busy,
  output logic             done
);

`ifdef PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  // gap counter holds GAP-1 down to 0
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? (GAP - 1) : 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]       state_r;
  logic [FRAME-1:0] shift_r;
  logic [CW-1:0]    bit_cnt_r;
  logic [GW-1:0]    gap_cnt_r;
  logic             a_r;
  logic             a_valid_r;
  logic             done_r;
  logic [FRAME-1:0] frame_s;
  logic             accept_s;

`ifdef PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  // Word to transmit in send order, parity bit last when enabled.
  always_comb begin
`ifdef PARITY_EN
    frame_s = {load_data, even_parity(load_data)};
`else
    frame_s = load_data;
`endif
  end

  assign load_ready = (state_r == ST_IDLE) && !reset;
  assign accept_s   = load_valid && load_ready;

  // Frame sequencer: load, shift out MSB-first, then idle gap.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      shift_r   <= '0;
      bit_cnt_r <= '0;
      gap_cnt_r <= '0;
      a_r       <= IDLE_BIT;
      a_valid_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r   <= ST_SHIFT;
            a_r       <= frame_s[FRAME-1];
            shift_r   <= frame_s << 1'b1;
            a_valid_r <= 1'b1;
            done_r    <= (FRAME == 1);
            bit_cnt_r <= CNT_LOAD;
          end else begin
            a_r       <= IDLE_BIT;
            a_valid_r <= 1'b0;
            done_r    <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (bit_cnt_r == '0) begin
            a_r       <= IDLE_BIT;
            a_valid_r <= 1'b0;
            done_r    <= 1'b0;
            gap_cnt_r <= GAP_LOAD;
            state_r   <= (GAP > 0) ? ST_GAP : ST_IDLE;
          end else begin
            a_r       <= shift_r[FRAME-1];
            shift_r   <= shift_r << 1'b1;
            bit_cnt_r <= bit_cnt_r - 1'b1;
            done_r    <= (bit_cnt_r == CW'(1));
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == '0) begin
            state_r <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r - 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          a_r       <= IDLE_BIT;
          a_valid_r <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign a       = a_r;
  assign a_valid = a_valid_r;
  assign done    = done_r;
  assign busy    = (state_r != ST_IDLE);

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: two instances (GAP=2 and GAP=0) checked every cycle
// against a queue-of-line-symbols model, plus table vectors and hand corner sequences.
module tb_serial_pattern_tx;
`ifdef PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset = 1'b1;
  logic       lv0 = 1'b0, lv1 = 1'b0;
  logic [7:0] ld0 = 8'h00, ld1 = 8'h00;
  logic       lr0, lr1, a0, a1, av0, av1, busy0, busy1, done0, done1;

  serial_pattern_tx #(.WIDTH(8), .GAP(2), .IDLE_BIT(1'b1)) dut (
    .clock(clock), .reset(reset), .load_valid(lv0), .load_ready(lr0), .load_data(ld0),
    .a(a0), .a_valid(av0), .busy(busy0), .done(done0));

  serial_pattern_tx #(.WIDTH(8), .GAP(0), .IDLE_BIT(1'b1)) dut_g0 (
    .clock(clock), .reset(reset), .load_valid(lv1), .load_ready(lr1), .load_data(ld1),
    .a(a1), .a_valid(av1), .busy(busy1), .done(done1));

  int checks = 0;
  int errors = 0;

  // Model: each accepted word becomes a list of line symbols {a, a_valid, done},
  // one per cycle: the frame bits, then the idle gap. Empty list means IDLE.
  logic [2:0] q0[$];
  logic [2:0] q1[$];

  function automatic logic [FRAME-1:0] frame_of(input logic [7:0] d);
`ifdef PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  always @(posedge clock) begin
    logic [FRAME-1:0] f;
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (q0.size() != 0) void'(q0.pop_front());
      else if (lv0) begin
        f = frame_of(ld0);
        for (int i = FRAME - 1; i >= 0; i--) q0.push_back({f[i], 1'b1, (i == 0)});
        for (int g = 0; g < 2; g++) q0.push_back(3'b100);
      end
      if (q1.size() != 0) void'(q1.pop_front());
      else if (lv1) begin
        f = frame_of(ld1);
        for (int i = FRAME - 1; i >= 0; i--) q1.push_back({f[i], 1'b1, (i == 0)});
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [2:0] e0, e1;
    e0 = (q0.size() != 0) ? q0[0] : 3'b100;
    e1 = (q1.size() != 0) ? q1[0] : 3'b100;
    chk("g2_a", a0, e0[2]);
    chk("g2_a_valid", av0, e0[1]);
    chk("g2_done", done0, e0[0]);
    chk("g2_busy", busy0, q0.size() != 0);
    chk("g2_ready", lr0, (q0.size() == 0) && !reset);
    chk("g0_a", a1, e1[2]);
    chk("g0_a_valid", av1, e1[1]);
    chk("g0_done", done1, e1[0]);
    chk("g0_busy", busy1, q1.size() != 0);
    chk("g0_ready", lr1, (q1.size() == 0) && !reset);
  endtask

  // One clock: step past the edge, then compare every output with the model.
  task automatic tick();
    @(posedge clock);
    #1;
    check_model();
  endtask

  task automatic wait_ready0();
    int n;
    n = 0;
    while (!lr0 && n < 50) begin
      tick();
      n++;
    end
    chk("wait_ready_timeout", lr0, 1'b1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;   // even parity worked out by hand
  } vec_t;
  vec_t tbl[6];

  initial begin
    logic [FRAME-1:0] got, want;
    int done_pos, gap_idle;
    bit seen_done;

    tbl[0] = '{8'b0101_0010, 1'b1};
    tbl[1] = '{8'hFF, 1'b0};
    tbl[2] = '{8'h07, 1'b1};
    tbl[3] = '{8'h00, 1'b0};
    tbl[4] = '{8'h80, 1'b1};
    tbl[5] = '{8'hA5, 1'b0};

    // Reset held two cycles with load_valid high: nothing accepted.
    reset = 1'b1; lv0 = 1'b1; lv1 = 1'b1; ld0 = 8'h3C; ld1 = 8'h3C;
    tick();
    tick();
    chk("reset_no_ready", lr0, 1'b0);
    chk("reset_line_idle", a0, 1'b1);
    chk("reset_not_busy", busy0, 1'b0);
    lv0 = 1'b0; lv1 = 1'b0; reset = 1'b0;
    tick();

    // Table vectors: send, capture the serial frame, check done, gap and ready.
    foreach (tbl[k]) begin
      wait_ready0();
      lv0 = 1'b1; ld0 = tbl[k].data;
      tick();
      lv0 = 1'b0;
      got = '0; done_pos = -1;
      for (int i = 0; i < FRAME; i++) begin
        got[FRAME-1-i] = a0;
        if (done0) done_pos = (done_pos == -1) ? i : 99;
        if (i < FRAME - 1) tick();
      end
`ifdef PARITY_EN
      want = {tbl[k].data, tbl[k].par};
`else
      want = tbl[k].data;
`endif
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL vec%0d_stream actual=%b required=%b", k, got, want);
      end
      checks++;
      if (done_pos != FRAME - 1) begin
        errors++;
        $display("FAIL vec%0d_done_pos actual=%0d required=%0d", k, done_pos, FRAME - 1);
      end
      tick(); chk("gap1_line", a0, 1'b1); chk("gap1_valid", av0, 1'b0);
      tick(); chk("gap2_line", a0, 1'b1); chk("gap2_busy", busy0, 1'b1);
      tick(); chk("ready_after_gap", lr0, 1'b1);
    end

    // load_valid held through a frame is ignored until the first IDLE cycle.
    lv0 = 1'b1; ld0 = 8'b0101_0010;
    tick();
    ld0 = 8'hFF;
    for (int c = 1; c <= 10; c++) begin
      chk("held_not_ready", lr0, 1'b0);
      tick();
    end
    chk("held_ready_c11", lr0, 1'b1);
    tick();
    lv0 = 1'b0;
    chk("second_word_bit", a0, 1'b1);
    chk("second_word_valid", av0, 1'b1);
    repeat (FRAME + 3) tick();

    // Reset mid-frame drops the rest; next word restarts from its MSB.
    wait_ready0();
    lv0 = 1'b1; ld0 = 8'h55;
    tick();
    lv0 = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_line", a0, 1'b1);
    chk("midreset_valid", av0, 1'b0);
    chk("midreset_busy", busy0, 1'b0);
    chk("midreset_done", done0, 1'b0);
    lv0 = 1'b1; ld0 = 8'h80;
    tick();
    lv0 = 1'b0;
    chk("restart_msb", a0, 1'b1);
    chk("restart_valid", av0, 1'b1);
    repeat (FRAME + 3) tick();

    // GAP=0 back-to-back: exactly one idle cycle between frames.
    lv1 = 1'b1;
    seen_done = 1'b0; gap_idle = 0;
    for (int c = 0; c < 4 * (FRAME + 1); c++) begin
      ld1 = 8'($urandom);
      tick();
      if (seen_done && av1) begin
        checks++;
        if (gap_idle != 1) begin
          errors++;
          $display("FAIL g0_idle_cycles actual=%0d required=1", gap_idle);
        end
        seen_done = 1'b0;
      end else if (seen_done && !av1) begin
        gap_idle++;
      end
      if (done1) begin
        seen_done = 1'b1;
        gap_idle = 0;
      end
    end
    lv1 = 1'b0;
    repeat (FRAME + 2) tick();

    // Randomized traffic on both instances with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      lv0 = 1'($urandom_range(0, 1));
      lv1 = 1'($urandom_range(0, 1));
      ld0 = 8'($urandom);
      ld1 = 8'($urandom);
      reset = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset = 1'b0; lv0 = 1'b0; lv1 = 1'b0;
    repeat (FRAME + 4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
